// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM register and the data bus: alignment and width checks,
// byte-lane steering, a single outstanding bus request with timeout, and load extension.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_data_width,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault,
  output logic        bus_err,
  output logic [31:0] fault_addr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     addr_q;
  logic [2:0]      width_q;

  logic        legal, aligned, access, start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_data;

  always_comb begin
    legal = 1'b0;
    case (mem_data_width)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    aligned = 1'b1;
    case (mem_data_width[1:0])
      2'b01:   aligned = ~mem_addr[0];
      2'b10:   aligned = (mem_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Rst gates the combinational outputs so an abort takes effect in the same cycle.
  assign access       = (mem_re | mem_we) & ~flush & ~rst & (state == StIdle);
  assign start        = access & legal & aligned;
  assign access_fault = access & ~(legal & aligned);
  assign mem_stall    = start | ((state == StWait) & ~rst);
  assign fault_addr   = access_fault ? mem_addr : (bus_err ? addr_q : 32'h0);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = mem_wdata;
    case (mem_data_width[1:0])
      2'b00: begin
        be_next    = 4'b0001 << mem_addr[1:0];
        wdata_next = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mem_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = mem_wdata;
      end
    endcase
  end

  always_comb begin
    lane_b   = dbus_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = dbus_rdata[{addr_q[1], 4'b0000} +: 16];
    ext_data = dbus_rdata;
    case (width_q)
      3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  ext_data = {24'h0, lane_b};
      3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  ext_data = {16'h0, lane_h};
      default: ext_data = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      addr_q     <= 32'h0;
      width_q    <= 3'b000;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_be    <= 4'b0000;
      dbus_wdata <= 32'h0;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StWait;
            cnt        <= '0;
            addr_q     <= mem_addr;
            width_q    <= mem_data_width;
            dbus_req   <= 1'b1;
            dbus_we    <= mem_we;
            dbus_addr  <= {mem_addr[31:2], 2'b00};
            dbus_be    <= be_next;
            dbus_wdata <= wdata_next;
          end
        end
        StWait: begin
          cnt <= cnt + 1'b1;
          if (dbus_ack) begin
            state      <= StDone;
            dbus_req   <= 1'b0;
            load_valid <= ~dbus_we;
            if (!dbus_we) load_data <= ext_data;
          end else if (cnt == CntW'(TIMEOUT - 1)) begin
            state    <= StDone;
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
          end
        end
        StDone: begin
          state      <= StIdle;
          load_valid <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; per-transaction expectations go through a scoreboard queue.
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_data_width;
  logic [31:0] mem_addr, mem_wdata, dbus_addr, dbus_wdata, dbus_rdata, load_data, fault_addr;
  logic        mem_we, mem_re, flush, dbus_req, dbus_we, dbus_ack;
  logic        mem_stall, load_valid, access_fault, bus_err;
  logic [3:0]  dbus_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] wd;
    int          waits;
    logic        lv;
    logic [31:0] ld;
    logic        berr;
    logic [31:0] fa;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_data_width(mem_data_width), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .flush(flush),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .access_fault(access_fault), .bus_err(bus_err), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [2:0] w, input logic [31:0] a);
    case (w[1:0])
      2'b00:   return (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                      (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] w, input logic [31:0] d);
    case (w[1:0])
      2'b00:   return d[7:0] * 32'h0101_0101;
      2'b01:   return d[15:0] * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (w)
      3'b000:  return (sh[7]  ? 32'hFFFF_FF00 : 32'h0) | (sh & 32'hFF);
      3'b100:  return sh & 32'hFF;
      3'b001:  return (sh[15] ? 32'hFFFF_0000 : 32'h0) | (sh & 32'hFFFF);
      3'b101:  return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // ack_at < 0 means never acknowledge (timeout path).
  task automatic txn(input string tag, input logic we, input logic re, input logic [2:0] w,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int ack_at, input logic flush_wait);
    exp_t e;
    int   waits = 0;
    int   stalls = 0;
    e.we    = we;
    e.be    = model_be(w, a);
    e.daddr = a & 32'hFFFF_FFFC;
    e.wd    = model_wd(w, wd);
    e.waits = (ack_at < 0) ? TO : ack_at;
    e.lv    = !we && (ack_at >= 0);
    e.ld    = model_load(w, a, rd);
    e.berr  = (ack_at < 0);
    e.fa    = (ack_at < 0) ? a : 32'h0;
    sb.push_back(e);

    @(negedge clk);
    mem_we = we; mem_re = re; mem_data_width = w; mem_addr = a; mem_wdata = wd;
    #1;
    chk({tag, " start stall"}, {31'h0, mem_stall}, 32'h1);
    chk({tag, " start fault"}, {31'h0, access_fault}, 32'h0);
    stalls = 1;
    @(negedge clk); #1;
    while (dbus_req === 1'b1 && waits < 64) begin
      waits++;
      stalls += mem_stall;
      if (waits == 1) begin
        chk({tag, " dbus_addr"}, dbus_addr, sb[0].daddr);
        chk({tag, " dbus_be"}, {28'h0, dbus_be}, {28'h0, sb[0].be});
        chk({tag, " dbus_we"}, {31'h0, dbus_we}, {31'h0, sb[0].we});
        if (sb[0].we) chk({tag, " dbus_wdata"}, dbus_wdata, sb[0].wd);
      end
      if (waits == ack_at) begin
        dbus_ack = 1'b1;
        dbus_rdata = rd;
      end
      flush = flush_wait;
      @(negedge clk);
      dbus_ack = 1'b0; flush = 1'b0; dbus_rdata = $urandom;
      #1;
    end

    e = sb.pop_front();
    chk({tag, " wait cycles"}, waits, e.waits);
    chk({tag, " stall cycles"}, stalls, e.waits + 1);
    chk({tag, " done stall"}, {31'h0, mem_stall}, 32'h0);
    chk({tag, " load_valid"}, {31'h0, load_valid}, {31'h0, e.lv});
    chk({tag, " bus_err"}, {31'h0, bus_err}, {31'h0, e.berr});
    chk({tag, " fault_addr"}, fault_addr, e.fa);
    if (e.lv) chk({tag, " load_data"}, load_data, e.ld);
    mem_we = 1'b0; mem_re = 1'b0;
    @(negedge clk); #1;
    chk({tag, " no restart"}, {31'h0, dbus_req}, 32'h0);
    chk({tag, " idle load_valid"}, {31'h0, load_valid}, 32'h0);
    chk({tag, " idle bus_err"}, {31'h0, bus_err}, 32'h0);
  endtask

  task automatic fault_chk(input string tag, input logic [2:0] w, input logic [31:0] a);
    @(negedge clk);
    mem_re = 1'b1; mem_data_width = w; mem_addr = a;
    #1;
    chk({tag, " access_fault"}, {31'h0, access_fault}, 32'h1);
    chk({tag, " fault_addr"}, fault_addr, a);
    chk({tag, " stall"}, {31'h0, mem_stall}, 32'h0);
    @(negedge clk); #1;
    chk({tag, " no req"}, {31'h0, dbus_req}, 32'h0);
    mem_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_data_width = 3'b000; mem_addr = 32'h0; mem_we = 1'b0; mem_re = 1'b0;
    mem_wdata = 32'h0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst dbus_req", {31'h0, dbus_req}, 32'h0);
    chk("rst dbus_be", {28'h0, dbus_be}, 32'h0);
    chk("rst dbus_addr", dbus_addr, 32'h0);
    chk("rst dbus_wdata", dbus_wdata, 32'h0);
    chk("rst load_data", load_data, 32'h0);
    chk("rst fault_addr", fault_addr, 32'h0);
    chk("rst flags", {26'h0, dbus_we, mem_stall, load_valid, bus_err, access_fault, 1'b0},
        32'h0);
    rst = 1'b0;

    txn("LB 0x103", 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0);
    txn("SH 0x202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 2, 1'b0);
    fault_chk("LW 0x105", 3'b010, 32'h105);
    fault_chk("LH 0x007", 3'b001, 32'h007);
    fault_chk("illegal 011", 3'b011, 32'h100);
    txn("LHU timeout", 1'b0, 1'b1, 3'b101, 32'h002, 32'h0, 32'h0, -1, 1'b0);
    txn("LBU 0x101", 1'b0, 1'b1, 3'b100, 32'h101, 32'h0, 32'h1234_80FE, 1, 1'b0);
    txn("LH 0x002", 1'b0, 1'b1, 3'b001, 32'h002, 32'h0, 32'h8001_0000, 4, 1'b0);
    txn("LW 0x010", 1'b0, 1'b1, 3'b010, 32'h010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    txn("SB re+we", 1'b1, 1'b1, 3'b000, 32'h001, 32'h0000_005A, 32'h0, 1, 1'b0);
    txn("SW flush wait", 1'b1, 1'b0, 3'b010, 32'h300, 32'h1357_9BDF, 32'h0, 2, 1'b1);

    // Flush in the start cycle squashes the access.
    @(negedge clk);
    mem_we = 1'b1; mem_data_width = 3'b010; mem_addr = 32'h400; flush = 1'b1;
    #1;
    chk("SW flush start stall", {31'h0, mem_stall}, 32'h0);
    chk("SW flush start fault", {31'h0, access_fault}, 32'h0);
    @(negedge clk);
    mem_we = 1'b0; flush = 1'b0;
    #1;
    chk("SW flush start no req", {31'h0, dbus_req}, 32'h0);

    // Reset during WAIT aborts; the late ack must be ignored.
    @(negedge clk);
    mem_re = 1'b1; mem_data_width = 3'b010; mem_addr = 32'h40;
    @(negedge clk); #1;
    chk("rst-abort wait1 req", {31'h0, dbus_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst-abort stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_re = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
    #1;
    chk("rst-abort req", {31'h0, dbus_req}, 32'h0);
    chk("rst-abort be", {28'h0, dbus_be}, 32'h0);
    chk("rst-abort addr", dbus_addr, 32'h0);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("rst-abort ack ignored lv", {31'h0, load_valid}, 32'h0);
    chk("rst-abort ack ignored ld", load_data, 32'h0);
    chk("rst-abort idle req", {31'h0, dbus_req}, 32'h0);

    // Stray ack in IDLE has no effect.
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'h1111_2222;
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("idle ack lv", {31'h0, load_valid}, 32'h0);
    chk("idle ack stall", {31'h0, mem_stall}, 32'h0);

    txn("LW after abort", 1'b0, 1'b1, 3'b010, 32'h044, 32'h0, 32'h0BAD_F00D, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles without dbus_ack before a bus error is raised.
REQ-002 SHALL have clk, input, 1, clock; all state updates on posedge clk.
REQ-003 SHALL have rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have mem_data_width, input, 3, access width code: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is illegal.
REQ-005 SHALL have mem_addr, input, 32, byte address of the access.
REQ-006 SHALL have mem_we and mem_re, input, 1 each, store and load request from the EX/MEM register.
REQ-007 SHALL have mem_wdata, input, 32, store data, right-aligned.
REQ-008 SHALL have flush, input, 1, which squashes an access not yet issued.
REQ-009 SHALL have dbus_req, dbus_we, output, 1 each; dbus_addr, output, 32; dbus_be, output, 4; dbus_wdata, output, 32.
REQ-010 SHALL have dbus_ack, input, 1, and dbus_rdata, input, 32, from the data bus.
REQ-011 SHALL have mem_stall, output, 1, which holds the upstream EX/MEM register and the stages before it.
REQ-012 SHALL have load_data, output, 32, the extended load result; and load_valid, output, 1.
REQ-013 SHALL have access_fault, output, 1, for a misaligned or illegal-width access; bus_err, output, 1, for a timeout; fault_addr, output, 32.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-015 Start condition in IDLE: (mem_re|mem_we) & aligned & legal-width & !flush -> SHALL go to WAIT next cycle, and SHALL assert mem_stall combinationally in that same cycle.
REQ-016 Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00; B/BU are always aligned.
REQ-017 In IDLE, a misaligned or illegal-width access SHALL assert access_fault combinationally, put mem_addr on fault_addr, issue no bus request, and assert no stall.
REQ-018 dbus_req SHALL be registered: high during every WAIT cycle, low otherwise.
REQ-019 dbus_addr, dbus_we, dbus_be and dbus_wdata SHALL be latched on entry to WAIT and held stable until exit from WAIT.
REQ-020 dbus_addr SHALL be {mem_addr[31:2],2'b00}.
REQ-021 Store byte enables: B -> be=1<<addr[1:0], wdata = byte replicated x4; H -> be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata = half replicated x2; W -> be=1111, wdata as given.
REQ-022 For loads, dbus_be SHALL be formed as for stores and dbus_we SHALL be 0.
REQ-023 In WAIT, mem_stall SHALL be 1 and a wait counter SHALL increment each cycle.
REQ-024 In WAIT with dbus_ack=1, the FSM SHALL capture dbus_rdata and go to DONE.
REQ-025 In WAIT, when the counter reaches TIMEOUT-1 without ack, the FSM SHALL go to DONE with bus_err latched to 1 and dbus_req dropped.
REQ-026 Load extraction SHALL select the lane by the latched addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes the word through.
REQ-027 In DONE, the FSM SHALL hold mem_stall=0, load_valid=1 for a completed load, and load_data valid, then return to IDLE next cycle.
REQ-028 bus_err SHALL be visible during DONE only, and fault_addr SHALL equal the latched address while bus_err is asserted.
REQ-029 The FSM SHALL NOT re-start on the DONE cycle; the upstream register advances at the end of DONE.
REQ-030 Minimum latency SHALL be: start cycle, 1 WAIT cycle with ack, DONE cycle -> 3 cycles, with 2 stall cycles.
REQ-031 Flush in WAIT SHALL be ignored; the transaction completes normally.
REQ-032 Flush in IDLE SHALL suppress the start and access_fault.
REQ-033 An ack outside WAIT SHALL be ignored.
REQ-034 mem_re and mem_we both high SHALL be treated as a store.
REQ-035 The wait counter SHALL be wide enough for TIMEOUT and SHALL clear on entry to WAIT.

Reset
REQ-036 On rst, the FSM SHALL go to IDLE and dbus_req, dbus_we, mem_stall, load_valid, bus_err and access_fault SHALL be 0.
REQ-037 On rst, dbus_be SHALL be 0 and dbus_addr, dbus_wdata, load_data, fault_addr and the counter SHALL be 0.
REQ-038 rst asserted in WAIT SHALL abort the transaction immediately; a later ack SHALL be ignored.

Verification
REQ-039 LB at addr 0x103, rdata 0x80FF_1234 with ack on the first WAIT cycle -> be=1000, dbus_addr=0x100, load_data=0xFFFF_FF80 in DONE, 2 stall cycles.
REQ-040 SH at 0x202, wdata 0x0000_ABCD -> be=1100, dbus_wdata=0xABCD_ABCD, dbus_we=1, load_valid=0 in DONE.
REQ-041 LW at 0x105 -> access_fault=1 and fault_addr=0x105 in the same cycle, dbus_req never rises, mem_stall=0.
REQ-042 LHU at 0x002 with no ack and TIMEOUT=16 -> 16 WAIT cycles, then DONE with bus_err=1 and fault_addr=0x002, then IDLE.
REQ-043 LW started, rst pulsed on the 2nd WAIT cycle, ack the next cycle -> all outputs 0 and state IDLE, ack ignored.
REQ-044 SW with flush in the start cycle -> no request and no stall; SW with flush during WAIT -> completes and ack accepted.
